tlc_phase_ctrl: RTL
===================

# tlc_phase_ctrl

Parametrised traffic-light phase controller for one main/side intersection. It sequences main green, main yellow, optional pedestrian walk, side green and side yellow from an internal down-counter, so no external timer is needed. Green phases adapt to the synchronised side-street sensor, and the three phase durations can be reprogrammed at run time. It sits between the input synchronisers (sensor, walk-request latch, program button) and the LED drivers.

## Interface
- `CNT_W`, 8: width of the phase counter and of the timing registers.
- `T_BASE`, 6: reset value of the base green duration, in cycles.
- `T_EXT`, 3: reset value of the extension and walk duration, in cycles.
- `T_YEL`, 2: reset value of the yellow duration, in cycles.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `sensor_sync`  in  1  side-street car present; already synchronised.
- `wr`  in  1  walk request, level-held by an external latch until it is cleared.
- `wr_reset`  out  1  one-cycle pulse that clears the external walk latch.
- `prog_sync`  in  1  one-cycle program strobe; already synchronised.
- `prog_sel`  in  2  register to program: 0 = base, 1 = ext, 2 = yel, 3 = ignored.
- `prog_val`  in  CNT_W  new duration value.
- `leds`  out  7  lamp drive `[Rm,Ym,Gm,Rs,Ys,Gs,Walk]`.
- `state`  out  3  current state code.
- `phase_start`  out  1  high in the first cycle of every state.

## Operation
- State codes and `leds` values:
  - MG1 = 0 and MG2 = 1: `leds` 0011000.
  - MY = 2: 0101000.
  - WALK = 3: 1001001.
  - SG1 = 4 and SGX = 5: 1000010.
  - SY = 6: 1000100.
- State durations (tb, te, ty are the timing registers):
  - MG1: tb cycles. MG2: tb cycles.
  - MY: ty cycles. WALK: te cycles.
  - SG1: tb cycles. SGX: te cycles. SY: ty cycles.
- Transitions, taken on the last cycle of a state (counter == 0):
  - MG1 -> MY if `sensor_sync` = 1 in that cycle, otherwise MG1 -> MG2.
  - MG2 -> MY.
  - MY -> WALK if `wr` = 1 in that cycle, otherwise MY -> SG1.
  - WALK -> SG1.
  - SG1 -> SGX if `sensor_sync` = 1 in that cycle, otherwise SG1 -> SY.
  - SGX -> SY.
  - SY -> MG1.
- `sensor_sync` and `wr` are sampled only in the decision cycles listed above and ignored elsewhere.
- Timing registers tb, te, ty are CNT_W bits wide. A parameter or `prog_val` of 0 is stored as 1, so every state lasts at least 1 cycle.
- Programming: when `prog_sync` = 1 and `prog_sel` is 0 to 2, the selected register takes `prog_val` (0 stored as 1) and the FSM restarts in MG1 on the next cycle, using the new value.
  - `prog_sel` = 3: no register changes, but the FSM still restarts.
  - `prog_sync` takes priority over any transition in the same cycle.
- An unused state code (7) recovers to MG1 with a full tb load on the next cycle.

## Timing
- Reset, asynchronous, while `rst_n` = 0:
  - state = MG1, `leds` = 0011000.
  - counter = T_BASE-1 (the tb reset value minus 1, 0 parameter stored as 1).
  - tb/te/ty = parameter values, 0 stored as 1.
  - `wr_reset` = 0, `phase_start` = 1.
- Reset mid-phase abandons the current phase immediately.
- Counter behaviour:
  - On state entry the counter loads duration-1.
  - It decrements every cycle.
  - The transition fires on the clock edge after the cycle in which it reads 0.
- `leds`, `state`, `phase_start` and `wr_reset` are all registered and change together on the entry edge. There is no combinational path from input to output.
- `wr_reset` is high exactly in the first WALK cycle.
- A `wr` still high at the next MY decision produces a second walk.

## Configuration
- Macro: `TLC_WALK_EN`.
- Defined: the WALK state and the `wr`/`wr_reset` handshake are implemented as described above.
- Undefined:
  - WALK logic is compiled out and MY always goes to SG1.
  - `wr` is ignored and `wr_reset` is tied to 0.
  - te still times SGX.

## Test plan
- Defaults, `sensor_sync` = 0, `wr` = 0, reset released -> MG1 6, MG2 6, MY 2, SG1 6, SY 2 cycles; period 22; `phase_start` high once per state.
- `sensor_sync` held at 1 -> MG1 6, MY 2, SG1 6, SGX 3, SY 2 cycles; period 19.
- `wr` = 1 before the MY decision cycle (macro defined) -> WALK entered for 3 cycles, `leds` = 1001001, one-cycle `wr_reset`, then SG1.
- Same stimulus with the macro undefined -> MY goes to SG1 and `wr_reset` stays 0.
- `prog_sync` with `prog_sel` = 0, `prog_val` = 4, issued mid-SG1 -> restart in MG1 next cycle; MG1 and MG2 each last 4 cycles.
- `prog_val` = 0 with `prog_sel` = 2, then assert `rst_n` = 0 mid-MY -> yellow lasts 1 cycle after programming; reset immediately returns to MG1, `leds` = 0011000, ty = 2.

Source files
------------

// File: rtl/tlc_phase_ctrl.sv
// tlc_phase_ctrl: main/side traffic-light phase controller with an internal
// down-counter, sensor-adaptive green extension and run-time programmable
// base / extension / yellow durations.
// Optional feature macro: TLC_WALK_EN enables the pedestrian WALK phase and
// the wr / wr_reset walk-latch handshake.
module tlc_phase_ctrl #(
  parameter int CNT_W  = 8,
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_sync,
  input  logic             wr,
  output logic             wr_reset,
  input  logic             prog_sync,
  input  logic [1:0]       prog_sel,
  input  logic [CNT_W-1:0] prog_val,
  output logic [6:0]       leds,
  output logic [2:0]       state,
  output logic             phase_start
);

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG1  = 3'd4,
    SGX  = 3'd5,
    SY   = 3'd6
  } state_t;

  // A zero duration would never let the counter expire cleanly, so zero
  // is promoted to one everywhere a duration is stored.
  localparam logic [CNT_W-1:0] TB_RST = (T_BASE == 0) ? CNT_W'(1) : CNT_W'(T_BASE);
  localparam logic [CNT_W-1:0] TE_RST = (T_EXT  == 0) ? CNT_W'(1) : CNT_W'(T_EXT);
  localparam logic [CNT_W-1:0] TY_RST = (T_YEL  == 0) ? CNT_W'(1) : CNT_W'(T_YEL);

  localparam logic [6:0] LED_MG   = 7'b0011000;
  localparam logic [6:0] LED_MY   = 7'b0101000;
  localparam logic [6:0] LED_WALK = 7'b1001001;
  localparam logic [6:0] LED_SG   = 7'b1000010;
  localparam logic [6:0] LED_SY   = 7'b1000100;
  localparam logic [6:0] LED_RED  = 7'b1001000;

  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  function automatic logic [6:0] leds_of(input state_t s);
    case (s)
      MG1, MG2: return LED_MG;
      MY:       return LED_MY;
      WALK:     return LED_WALK;
      SG1, SGX: return LED_SG;
      SY:       return LED_SY;
      default:  return LED_RED;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tb_q, tb_d, te_q, te_d, ty_q, ty_d;
  logic [6:0]       leds_q, leds_d;
  logic             ps_q, ps_d;
  logic             load;
  logic             walk_req;

`ifdef TLC_WALK_EN
  assign walk_req = wr;
`else
  wire unused_wr;
  assign unused_wr = wr;
  assign walk_req  = 1'b0;
`endif

  // Next-state, counter reload and timing-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    tb_d    = tb_q;
    te_d    = te_q;
    ty_d    = ty_q;
    load    = 1'b0;
    if (prog_sync) begin
      case (prog_sel)
        2'd0:    tb_d = nz(prog_val);
        2'd1:    te_d = nz(prog_val);
        2'd2:    ty_d = nz(prog_val);
        default: ;
      endcase
      state_d = MG1;
      load    = 1'b1;
    end else if (cnt_q == '0 || state_q > SY) begin
      load = 1'b1;
      case (state_q)
        MG1:     state_d = sensor_sync ? MY : MG2;
        MG2:     state_d = MY;
        MY:      state_d = walk_req ? WALK : SG1;
        WALK:    state_d = SG1;
        SG1:     state_d = sensor_sync ? SGX : SY;
        SGX:     state_d = SY;
        SY:      state_d = MG1;
        default: state_d = MG1;
      endcase
    end
    if (load) begin
      case (state_d)
        MY, SY:    cnt_d = ty_d - CNT_W'(1);
        WALK, SGX: cnt_d = te_d - CNT_W'(1);
        default:   cnt_d = tb_d - CNT_W'(1);
      endcase
    end
    leds_d = leds_of(state_d);
    ps_d   = load;
  end

  // State, counter, timing registers and registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MG1;
      cnt_q   <= TB_RST - CNT_W'(1);
      tb_q    <= TB_RST;
      te_q    <= TE_RST;
      ty_q    <= TY_RST;
      leds_q  <= LED_MG;
      ps_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tb_q    <= tb_d;
      te_q    <= te_d;
      ty_q    <= ty_d;
      leds_q  <= leds_d;
      ps_q    <= ps_d;
    end
  end

`ifdef TLC_WALK_EN
  logic wr_reset_q, wr_reset_d;

  // Walk-latch clear pulse, high only in the first WALK cycle.
  always_comb begin
    wr_reset_d = load && (state_d == WALK);
  end

  // Registered so the pulse is aligned with the WALK entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_reset_q <= 1'b0;
    else        wr_reset_q <= wr_reset_d;
  end

  assign wr_reset = wr_reset_q;
`else
  assign wr_reset = 1'b0;
`endif

  assign leds        = leds_q;
  assign state       = state_q;
  assign phase_start = ps_q;

endmodule
